alu_rs_scheduler: RTL

Reservation station and issue scheduler for the integer ALU in the out-of-order core. Accepts decoded ALU-class instructions (LUI through SRAI, including branches and jumps) from dispatch and holds them until both source operands are available. Snoops the ALU and load/store result broadcast buses for operand wakeup. Selects at most one ready entry per cycle and presents it to the ALU as a registered one-cycle issue pulse.

---
 rtl/alu_rs_scheduler.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/alu_rs_scheduler.sv
// Reservation station for the integer ALU: holds dispatched ops until both
// operands are available, snoops both result buses, and issues one ready op per cycle.
module alu_rs_scheduler #(
  parameter int ENTRIES = 16,
  parameter int ROB_W   = 4,
  parameter int OP_W    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,

  input  logic             dsp_valid,
  input  logic [OP_W-1:0]  dsp_op_id,
  input  logic [31:0]      dsp_inst_pc,
  input  logic [31:0]      dsp_vj,
  input  logic [31:0]      dsp_vk,
  input  logic             dsp_qj_valid,
  input  logic             dsp_qk_valid,
  input  logic [ROB_W-1:0] dsp_qj,
  input  logic [ROB_W-1:0] dsp_qk,
  input  logic [31:0]      dsp_imm,
  input  logic [ROB_W-1:0] dsp_rob_id,
  output logic             rs_full,

  input  logic             cdb_alu_valid,
  input  logic [ROB_W-1:0] cdb_alu_rob_id,
  input  logic [31:0]      cdb_alu_value,
  input  logic             cdb_lsb_valid,
  input  logic [ROB_W-1:0] cdb_lsb_rob_id,
  input  logic [31:0]      cdb_lsb_value,

  output logic             alu_valid,
  output logic [OP_W-1:0]  alu_op_id,
  output logic [31:0]      alu_inst_pc,
  output logic [31:0]      alu_rs1,
  output logic [31:0]      alu_rs2,
  output logic [31:0]      alu_imm,
  output logic [ROB_W-1:0] alu_rob_id,

  input  logic             roll_back_flag
);

  localparam int IDX_W = $clog2(ENTRIES);

  typedef struct packed {
    logic [OP_W-1:0]  op_id;
    logic [31:0]      pc;
    logic [31:0]      vj;
    logic [31:0]      vk;
    logic             qj_valid;
    logic [ROB_W-1:0] qj;
    logic             qk_valid;
    logic [ROB_W-1:0] qk;
    logic [31:0]      imm;
    logic [ROB_W-1:0] rob_id;
  } entry_t;

  entry_t             ent [ENTRIES];
  logic [ENTRIES-1:0] busy;
  logic [ENTRIES-1:0] busy_next;
  logic [ENTRIES-1:0] ready;
  logic               sel_found;
  logic [IDX_W-1:0]   sel_idx;
  logic [IDX_W-1:0]   free_idx;
  logic               alloc_en;
  entry_t             new_entry;

  // ALU bus wins when both buses carry the same tag.
  function automatic logic cdb_hit(input logic [ROB_W-1:0] tag);
    return (cdb_alu_valid && cdb_alu_rob_id == tag) ||
           (cdb_lsb_valid && cdb_lsb_rob_id == tag);
  endfunction

  function automatic logic [31:0] cdb_value(input logic [ROB_W-1:0] tag);
    return (cdb_alu_valid && cdb_alu_rob_id == tag) ? cdb_alu_value : cdb_lsb_value;
  endfunction

  assign rs_full  = &busy;
  assign alloc_en = dsp_valid && !rs_full;

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      ready[i] = busy[i] && !ent[i].qj_valid && !ent[i].qk_valid;
    end
  end

  // Scan from the top so the lowest index is the last (winning) assignment.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    sel_found = 1'b0;
    sel_idx   = '0;
    free_idx  = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (ready[i]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
      if (!busy[i]) free_idx = IDX_W'(i);
    end
  end

  // Incoming entry, with operands captured from a same-cycle broadcast.
  always_comb begin
    new_entry.op_id    = dsp_op_id;
    new_entry.pc       = dsp_inst_pc;
    new_entry.imm      = dsp_imm;
    new_entry.rob_id   = dsp_rob_id;
    new_entry.qj       = dsp_qj;
    new_entry.qk       = dsp_qk;
    new_entry.vj       = dsp_vj;
    new_entry.vk       = dsp_vk;
    new_entry.qj_valid = dsp_qj_valid;
    new_entry.qk_valid = dsp_qk_valid;
    if (dsp_qj_valid && cdb_hit(dsp_qj)) begin
      new_entry.vj       = cdb_value(dsp_qj);
      new_entry.qj_valid = 1'b0;
    end
    if (dsp_qk_valid && cdb_hit(dsp_qk)) begin
      new_entry.vk       = cdb_value(dsp_qk);
      new_entry.qk_valid = 1'b0;
    end
  end

  // Allocation only ever targets an entry that was free before this edge.
  always_comb begin
    busy_next = busy;
    if (sel_found) busy_next[sel_idx] = 1'b0;
    if (alloc_en)  busy_next[free_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      busy        <= '0;
      alu_valid   <= 1'b0;
      alu_op_id   <= '0;
      alu_inst_pc <= '0;
      alu_rs1     <= '0;
      alu_rs2     <= '0;
      alu_imm     <= '0;
      alu_rob_id  <= '0;
    end else if (rdy) begin
      if (roll_back_flag) begin
        busy      <= '0;
        alu_valid <= 1'b0;
      end else begin
        busy      <= busy_next;
        alu_valid <= sel_found;
        if (sel_found) begin
          alu_op_id   <= ent[sel_idx].op_id;
          alu_inst_pc <= ent[sel_idx].pc;
          alu_rs1     <= ent[sel_idx].vj;
          alu_rs2     <= ent[sel_idx].vk;
          alu_imm     <= ent[sel_idx].imm;
          alu_rob_id  <= ent[sel_idx].rob_id;
        end
      end
    end
  end

  // NOTE: entry payload is not reset; it is only observed through a busy bit, which is.
  always_ff @(posedge clk) begin
    if (rdy && !rst && !roll_back_flag) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (busy[i]) begin
          if (ent[i].qj_valid && cdb_hit(ent[i].qj)) begin
            ent[i].vj       <= cdb_value(ent[i].qj);
            ent[i].qj_valid <= 1'b0;
          end
          if (ent[i].qk_valid && cdb_hit(ent[i].qk)) begin
            ent[i].vk       <= cdb_value(ent[i].qk);
            ent[i].qk_valid <= 1'b0;
          end
        end
      end
      if (alloc_en) ent[free_idx] <= new_entry;
    end
  end

endmodule
